square_seq: RTL and testbench

Sequential shift-add squarer: the inverse operation of the team's `sqrt` block. It takes an unsigned root and produces its exact square over a fixed number of cycles. It uses the same start/ready handshake as `sqrt`, so a sweep engine or checker can chain `square_seq` into `sqrt` for round-trip verification. It also flags any square that `sqrt` cannot accept back as a positive signed 32-bit input.

---
 rtl/square_pkg.sv | 20 ++
 rtl/square_dp.sv | 50 +++++
 rtl/square_seq.sv | 91 +++++++++
 tb/tb_square_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/square_pkg.sv
// Shared constants and state type for the sequential squarer.
// The sqrt block and the system bench import SQ_W so both widths stay matched.
package square_pkg;

  localparam int SQ_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int SQ_CNT_W = cnt_width(SQ_W);

endpackage

// File: rtl/square_dp.sv
// Shift-add datapath: accumulator, left-shifting multiplicand, right-shifting multiplier.
// `sum` is the accumulator plus the current partial product.
module square_dp
  import square_pkg::*;
#(
  parameter int W = SQ_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] sum
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mult_q, mult_d;
  logic [2*W-1:0] addend;

  always_comb begin
    addend  = mult_q[0] ? mcand_q : '0;
    sum     = acc_q + addend;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    if (load) begin
      acc_d   = '0;
      mcand_d = {{W{1'b0}}, operand};
      mult_d  = operand;
    end else if (step) begin
      acc_d   = sum;
      mcand_d = mcand_q << 1;
      mult_d  = mult_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mult_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
    end
  end

endmodule

// File: rtl/square_seq.sv
// Sequential squarer: W shift-add iterations after acceptance, then a one-cycle ready pulse.
// Oflag marks squares that do not fit a positive signed 2W-bit value.
module square_seq
  import square_pkg::*;
#(
  parameter int W = SQ_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   operand,
  output logic           ready,
  output logic           busy,
  output logic [2*W-1:0] result,
  output logic           Oflag
);

  localparam int CNT_W = cnt_width(W);

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] result_q, result_d;
  logic           oflag_q, oflag_d;
  logic           ready_q, ready_d;
  logic           load, step;
  logic [2*W-1:0] sum;

  square_dp #(.W(W)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .operand (operand),
    .sum     (sum)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    oflag_d  = oflag_q;
    ready_d  = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // The last iteration captures acc plus its final partial product directly.
        if (cnt_q == CNT_W'(W - 1)) begin
          result_d = sum;
          oflag_d  = sum[2*W-1];
          ready_d  = 1'b1;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      oflag_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      oflag_q  <= oflag_d;
      ready_q  <= ready_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = (state_q != IDLE);
  assign result = result_q;
  assign Oflag  = oflag_q;

endmodule

// File: tb/tb_square_seq.sv
// Self-checking bench for square_seq: directed boundaries plus randomized squares
// checked against plain multiplication and an integer square-root round trip.
module tb_square_seq;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   operand = '0;
  logic           ready;
  logic           busy;
  logic [2*W-1:0] result;
  logic           Oflag;

  int n_cmp = 0;
  int n_fail = 0;

  square_seq #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .operand (operand),
    .ready   (ready),
    .busy    (busy),
    .result  (result),
    .Oflag   (Oflag)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned r = 0;
    longint unsigned t;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction

  // Drives one request and waits (bounded) for ready; scrambles operand after edge 1.
  task automatic run_op(input logic [W-1:0] x, output int lat, output logic [2*W-1:0] res,
                        output logic ofl, output bit tmo, output bit busy_ok);
    @(negedge clk);
    start = 1'b1;
    operand = x;
    @(posedge clk);
    tmo = 1'b1;
    lat = -1;
    busy_ok = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) begin
        start = 1'b0;
        operand = W'($urandom);
      end
      if (!busy) busy_ok = 1'b0;
      if (ready) begin
        lat = e;
        tmo = 1'b0;
        break;
      end
    end
    res = result;
    ofl = Oflag;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] x);
    int lat;
    logic [2*W-1:0] res;
    logic ofl;
    bit tmo, bok;
    longint unsigned sq;
    sq = longint'(x) * longint'(x);
    run_op(x, lat, res, ofl, tmo, bok);
    n_cmp++;
    if (tmo) begin
      n_fail++;
      $display("[TB] FAIL %s timeout: no ready within 100 edges, required at edge %0d", name, W);
    end
    n_cmp++;
    if (lat !== W) begin
      n_fail++;
      $display("[TB] FAIL %s latency: got %0d edges, expected %0d", name, lat, W);
    end
    n_cmp++;
    if (res !== sq[2*W-1:0]) begin
      n_fail++;
      $display("[TB] FAIL %s result: got 0x%08h, expected 0x%08h", name, res, sq[2*W-1:0]);
    end
    n_cmp++;
    if (ofl !== (sq >= (64'd1 << (2*W-1)))) begin
      n_fail++;
      $display("[TB] FAIL %s Oflag: got %b, expected %b", name, ofl, sq >= (64'd1 << (2*W-1)));
    end
  endtask

  task automatic test_reset();
    int lat;
    logic [2*W-1:0] res;
    logic ofl;
    bit tmo, bok;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ready, busy, result, Oflag} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_hold outputs: got r=%b b=%b res=0x%h o=%b, expected all 0",
               ready, busy, result, Oflag);
    end
    rst = 1'b1;
    run_op(16'd60000, lat, res, ofl, tmo, bok);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({ready, busy, result, Oflag} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle outputs: got r=%b b=%b res=0x%h o=%b, expected all 0",
               ready, busy, result, Oflag);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [2*W-1:0] res;
    logic ofl;
    bit tmo, bok;
    run_op(16'd3, lat, res, ofl, tmo, bok);
    n_cmp++;
    if (lat !== 16) begin
      n_fail++;
      $display("[TB] FAIL basic latency: got %0d, expected 16", lat);
    end
    n_cmp++;
    if (res !== 32'd9 || ofl !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic square: got 0x%h o=%b, expected 0x9 o=0", res, ofl);
    end
    n_cmp++;
    if (!bok) begin
      n_fail++;
      $display("[TB] FAIL basic busy: busy=0 during run, expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0 || result !== 32'd9) begin
      n_fail++;
      $display("[TB] FAIL basic after_done: got r=%b b=%b res=0x%h, expected r=0 b=0 res=0x9",
               ready, busy, result);
    end
  endtask

  task automatic test_overflow_boundary();
    check_op("ovf_46340", 16'd46340);
    n_cmp++;
    if (result !== 32'h7FFEA810 || Oflag !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ovf_46340 const: got 0x%h o=%b, expected 0x7ffea810 o=0", result, Oflag);
    end
    check_op("ovf_46341", 16'd46341);
    n_cmp++;
    if (result !== 32'h80001219 || Oflag !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ovf_46341 const: got 0x%h o=%b, expected 0x80001219 o=1", result, Oflag);
    end
  endtask

  task automatic test_extremes();
    check_op("max", 16'hFFFF);
    n_cmp++;
    if (result !== 32'hFFFE0001 || Oflag !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL max const: got 0x%h o=%b, expected 0xfffe0001 o=1", result, Oflag);
    end
    check_op("zero", 16'd0);
  endtask

  task automatic test_back_to_back();
    int first, second, pulses;
    logic [2*W-1:0] r1, r2;
    first = -1;
    second = -1;
    r1 = '0;
    r2 = '0;
    @(negedge clk);
    start = 1'b1;
    operand = 16'd5;
    @(posedge clk);
    for (int k = 1; k <= 80 && second < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) operand = 16'd7;
      if (ready) begin
        if (first < 0) begin
          first = k;
          r1 = result;
        end else begin
          second = k;
          r2 = result;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (first !== 16 || r1 !== 32'd25) begin
      n_fail++;
      $display("[TB] FAIL b2b first: got edge %0d res=%0d, expected edge 16 res=25", first, r1);
    end
    n_cmp++;
    if (second - first !== 18 || second < 0) begin
      n_fail++;
      $display("[TB] FAIL b2b spacing: got %0d edges, expected 18", second - first);
    end
    n_cmp++;
    if (r2 !== 32'd49) begin
      n_fail++;
      $display("[TB] FAIL b2b second: got %0d, expected 49", r2);
    end
    repeat (3) @(negedge clk);

    // A start pulse while running must not queue another operation.
    pulses = 0;
    first = -1;
    start = 1'b1;
    operand = 16'd9;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = (k == 5);
      if (ready) begin
        pulses++;
        if (first < 0) begin
          first = k;
          r1 = result;
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (pulses !== 1 || first !== 16 || r1 !== 32'd81) begin
      n_fail++;
      $display("[TB] FAIL start_in_run: got %0d pulses first=%0d res=%0d, expected 1 pulse at 16 res=81",
               pulses, first, r1);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    @(negedge clk);
    start = 1'b1;
    operand = 16'd200;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({ready, busy, result, Oflag} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_run outputs: got r=%b b=%b res=0x%h o=%b, expected all 0",
               ready, busy, result, Oflag);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_run ghost_ready: got %0d pulses, expected 0", pulses);
    end
    check_op("after_reset_12", 16'd12);
  endtask

  task automatic test_random_roundtrip();
    int lat;
    logic [2*W-1:0] res;
    logic ofl;
    bit tmo, bok;
    logic [W-1:0] x;
    longint unsigned sq;
    for (int i = 0; i < 300; i++) begin
      x = (i % 2 == 0) ? W'($urandom_range(0, 46340)) : W'($urandom);
      sq = longint'(x) * longint'(x);
      run_op(x, lat, res, ofl, tmo, bok);
      n_cmp++;
      if (tmo || lat !== W || res !== sq[2*W-1:0] || ofl !== sq[2*W-1]) begin
        n_fail++;
        $display("[TB] FAIL random x=%0d: got res=%0d o=%b lat=%0d, expected res=%0d o=%b lat=%0d",
                 x, res, ofl, lat, sq[2*W-1:0], sq[2*W-1], W);
      end
      if (!ofl && !tmo) begin
        n_cmp++;
        if (isqrt(longint'(res)) !== longint'(x)) begin
          n_fail++;
          $display("[TB] FAIL roundtrip x=%0d: sqrt(res) got %0d, expected %0d",
                   x, isqrt(longint'(res)), x);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_boundary();
    test_extremes();
    test_back_to_back();
    test_reset_mid_run();
    test_random_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
